// File: rtl/timer_pkg.sv
// Shared widths, limits, FSM states and preset clamp helpers for the MM:SS timers.
package timer_pkg;

  localparam int UNITS_W      = 4;
  localparam int TENS_W       = 3;
  localparam int UNITS_MAX    = 9;
  localparam int TENS_MAX_DEF = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Units digits above 9 saturate at 9.
  function automatic logic [UNITS_W-1:0] clamp_units(input logic [UNITS_W-1:0] v);
    return (v > UNITS_W'(UNITS_MAX)) ? UNITS_W'(UNITS_MAX) : v;
  endfunction

  // Tens digits above their maximum saturate at that maximum.
  function automatic logic [TENS_W-1:0] clamp_tens(input logic [TENS_W-1:0] v,
                                                   input logic [TENS_W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/countdown_mmss_if.sv
// Control/preset/display bundle for countdown_mmss; master drives the controls.
interface countdown_mmss_if
  import timer_pkg::*;
  ();

  logic              tick;
  logic              load;
  logic              start;
  logic              pause;
  logic              clear;
  logic [UNITS_W-1:0] preset_su;
  logic [TENS_W-1:0]  preset_st;
  logic [UNITS_W-1:0] preset_mu;
  logic [TENS_W-1:0]  preset_mt;
  logic [UNITS_W-1:0] out1;
  logic [TENS_W-1:0]  out2;
  logic [UNITS_W-1:0] out3;
  logic [TENS_W-1:0]  out4;
  logic              running;
  logic              expired;
  logic              alarm;

  modport master (
    output tick, load, start, pause, clear,
    output preset_su, preset_st, preset_mu, preset_mt,
    input  out1, out2, out3, out4, running, expired, alarm
  );

  modport slave (
    input  tick, load, start, pause, clear,
    input  preset_su, preset_st, preset_mu, preset_mt,
    output out1, out2, out3, out4, running, expired, alarm
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: wraps 0 -> MAX with a borrow, clear beats load beats decrement.
module bcd_down_digit #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             borrow_out
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] q_q, q_d;

  // Next digit value from clear/load/decrement.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (dec_en) begin
      q_d = (q_q == '0) ? MAX_V : q_q - WIDTH'(1);
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q          = q_q;
  assign borrow_out = dec_en && (q_q == '0);

endmodule

// File: rtl/countdown_mmss.sv
// MM:SS BCD countdown timer: control FSM, preset clamp, digit cascade and alarm counter.
module countdown_mmss
  import timer_pkg::*;
#(
  parameter int ALARM_TICKS  = 10,
  parameter int SEC_TENS_MAX = TENS_MAX_DEF,
  parameter int MIN_TENS_MAX = TENS_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic [UNITS_W-1:0] preset_su,
  input  logic [TENS_W-1:0]  preset_st,
  input  logic [UNITS_W-1:0] preset_mu,
  input  logic [TENS_W-1:0]  preset_mt,
  output logic [UNITS_W-1:0] out1,
  output logic [TENS_W-1:0]  out2,
  output logic [UNITS_W-1:0] out3,
  output logic [TENS_W-1:0]  out4,
  output logic               running,
  output logic               expired,
  output logic               alarm
);

  localparam logic [TENS_W-1:0] ST_MAX    = TENS_W'(SEC_TENS_MAX);
  localparam logic [TENS_W-1:0] MT_MAX    = TENS_W'(MIN_TENS_MAX);
  localparam logic [7:0]        ALARM_LIM = 8'(ALARM_TICKS);

  state_t     state_q, state_d;
  logic [7:0] acnt_q, acnt_d;

  logic dig_clr, dig_ld, dec_su;
  logic b_su, b_st, b_mu, b_mt_unused;
  logic is_zero, is_one;

  logic [UNITS_W-1:0] su_q, mu_q;
  logic [TENS_W-1:0]  st_q, mt_q;

  assign is_zero = (su_q == '0) && (st_q == '0) && (mu_q == '0) && (mt_q == '0);
  assign is_one  = (su_q == UNITS_W'(1)) && (st_q == '0) && (mu_q == '0) && (mt_q == '0);

  // Control FSM and alarm counter next state; clear > load > pause > start > tick.
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    dig_clr = 1'b0;
    dig_ld  = 1'b0;
    dec_su  = 1'b0;
    if (clear) begin
      dig_clr = 1'b1;
      state_d = IDLE;
      acnt_d  = '0;
    end else if (load) begin
      dig_ld  = 1'b1;
      state_d = IDLE;
      acnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause && start && !is_zero) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            dec_su = 1'b1;
            // 00:01 reaches 00:00 on this edge, so expiry is decided from the old value.
            if (is_one) begin
              state_d = EXPIRED;
              acnt_d  = '0;
            end
          end
        end
        PAUSE: begin
          if (!pause && start) state_d = RUN;
        end
        EXPIRED: begin
          if (tick && (acnt_q < ALARM_LIM)) acnt_d = acnt_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and alarm counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
    end
  end

  bcd_down_digit #(.WIDTH(UNITS_W), .MAX(UNITS_MAX)) u_su (
    .clk(clk), .rst(rst), .load(dig_ld), .load_val(clamp_units(preset_su)),
    .dec_en(dec_su), .clear(dig_clr), .q(su_q), .borrow_out(b_su)
  );

  bcd_down_digit #(.WIDTH(TENS_W), .MAX(SEC_TENS_MAX)) u_st (
    .clk(clk), .rst(rst), .load(dig_ld), .load_val(clamp_tens(preset_st, ST_MAX)),
    .dec_en(b_su), .clear(dig_clr), .q(st_q), .borrow_out(b_st)
  );

  bcd_down_digit #(.WIDTH(UNITS_W), .MAX(UNITS_MAX)) u_mu (
    .clk(clk), .rst(rst), .load(dig_ld), .load_val(clamp_units(preset_mu)),
    .dec_en(b_st), .clear(dig_clr), .q(mu_q), .borrow_out(b_mu)
  );

  bcd_down_digit #(.WIDTH(TENS_W), .MAX(MIN_TENS_MAX)) u_mt (
    .clk(clk), .rst(rst), .load(dig_ld), .load_val(clamp_tens(preset_mt, MT_MAX)),
    .dec_en(b_mu), .clear(dig_clr), .q(mt_q), .borrow_out(b_mt_unused)
  );

  assign out1    = su_q;
  assign out2    = st_q;
  assign out3    = mu_q;
  assign out4    = mt_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign alarm   = (state_q == EXPIRED) && (acnt_q < ALARM_LIM);

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: vector table, directed corner sequences, random run vs seconds model.
module tb_countdown_mmss;

  localparam int ALARM_N = 10;

  logic clk = 1'b0;
  logic rst;
  countdown_mmss_if cif ();

  always #5 clk = ~clk;

  countdown_mmss #(.ALARM_TICKS(ALARM_N), .SEC_TENS_MAX(5), .MIN_TENS_MAX(5)) dut (
    .clk(clk), .rst(rst),
    .tick(cif.tick), .load(cif.load), .start(cif.start), .pause(cif.pause), .clear(cif.clear),
    .preset_su(cif.preset_su), .preset_st(cif.preset_st),
    .preset_mu(cif.preset_mu), .preset_mt(cif.preset_mt),
    .out1(cif.out1), .out2(cif.out2), .out3(cif.out3), .out4(cif.out4),
    .running(cif.running), .expired(cif.expired), .alarm(cif.alarm)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: whole seconds remaining, mode (0 idle, 1 run, 2 pause, 3 expired), ticks since expiry.
  int m_secs = 0;
  int m_mode = 0;
  int m_acnt = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [16:0] pk(int mt, int mu, int st, int su, bit r, bit e, bit a);
    return {3'(mt), 4'(mu), 3'(st), 4'(su), r, e, a};
  endfunction

  function automatic string fmt(logic [16:0] v);
    return $sformatf("%0d%0d:%0d%0d run=%0b exp=%0b alm=%0b",
                     v[16:14], v[13:10], v[9:7], v[6:3], v[2], v[1], v[0]);
  endfunction

  function automatic logic [16:0] model_vec();
    return pk(m_secs / 600, (m_secs / 60) % 10, (m_secs % 60) / 10, m_secs % 10,
              m_mode == 1, m_mode == 3, (m_mode == 3) && (m_acnt < ALARM_N));
  endfunction

  task automatic model_step(input bit r, t, l, s, p, c, input int mt, mu, st, su);
    if (r || c) begin
      m_secs = 0; m_mode = 0; m_acnt = 0;
    end else if (l) begin
      m_secs = imin(mt, 5) * 600 + imin(mu, 9) * 60 + imin(st, 5) * 10 + imin(su, 9);
      m_mode = 0; m_acnt = 0;
    end else begin
      case (m_mode)
        0: if (!p && s && m_secs != 0) m_mode = 1;
        1: begin
          if (p) m_mode = 2;
          else if (t) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin m_mode = 3; m_acnt = 0; end
          end
        end
        2: if (!p && s) m_mode = 1;
        default: if (t && m_acnt < ALARM_N) m_acnt = m_acnt + 1;
      endcase
    end
  endtask

  task automatic drive(input bit r, t, l, s, p, c, input int mt, mu, st, su);
    rst = r; cif.tick = t; cif.load = l; cif.start = s; cif.pause = p; cif.clear = c;
    cif.preset_mt = 3'(mt); cif.preset_mu = 4'(mu);
    cif.preset_st = 3'(st); cif.preset_su = 4'(su);
    model_step(r, t, l, s, p, c, mt & 7, mu & 15, st & 7, su & 15);
    @(posedge clk);
    #1;
    rst = 1'b0; cif.tick = 1'b0; cif.load = 1'b0;
    cif.start = 1'b0; cif.pause = 1'b0; cif.clear = 1'b0;
  endtask

  task automatic check(input string name, input logic [16:0] want);
    logic [16:0] got;
    got = {cif.out4, cif.out3, cif.out2, cif.out1, cif.running, cif.expired, cif.alarm};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %s want %s", name, fmt(got), fmt(want));
    end
  endtask

  task automatic tick1();  drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic start1(); drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic load1(input int mt, mu, st, su); drive(0, 0, 1, 0, 0, 0, mt, mu, st, su); endtask

  typedef struct {
    string       name;
    bit          r, t, l, s, p, c;
    int          mt, mu, st, su;
    logic [16:0] want;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    cif.tick = 1'b0; cif.load = 1'b0; cif.start = 1'b0; cif.pause = 1'b0; cif.clear = 1'b0;
    cif.preset_mt = '0; cif.preset_mu = '0; cif.preset_st = '0; cif.preset_su = '0;

    tbl.push_back('{"reset",            1,0,0,0,0,0, 0, 0,0, 0, pk(0,0,0,0,0,0,0)});
    tbl.push_back('{"clamp_load",       0,0,1,0,0,0, 6,15,7,12, pk(5,9,5,9,0,0,0)});
    tbl.push_back('{"start_5959",       0,0,0,1,0,0, 0, 0,0, 0, pk(5,9,5,9,1,0,0)});
    tbl.push_back('{"tick_5958",        0,1,0,0,0,0, 0, 0,0, 0, pk(5,9,5,8,1,0,0)});
    tbl.push_back('{"pause",            0,0,0,0,1,0, 0, 0,0, 0, pk(5,9,5,8,0,0,0)});
    tbl.push_back('{"tick_paused",      0,1,0,0,0,0, 0, 0,0, 0, pk(5,9,5,8,0,0,0)});
    tbl.push_back('{"resume_drop_tick", 0,1,0,1,0,0, 0, 0,0, 0, pk(5,9,5,8,1,0,0)});
    tbl.push_back('{"tick_5957",        0,1,0,0,0,0, 0, 0,0, 0, pk(5,9,5,7,1,0,0)});
    tbl.push_back('{"load_1000",        0,0,1,0,0,0, 1, 0,0, 0, pk(1,0,0,0,0,0,0)});
    tbl.push_back('{"start_1000",       0,0,0,1,0,0, 0, 0,0, 0, pk(1,0,0,0,1,0,0)});
    tbl.push_back('{"borrow_0959",      0,1,0,0,0,0, 0, 0,0, 0, pk(0,9,5,9,1,0,0)});
    tbl.push_back('{"clear",            0,0,0,0,0,1, 0, 0,0, 0, pk(0,0,0,0,0,0,0)});
    tbl.push_back('{"start_at_zero",    0,0,0,1,0,0, 0, 0,0, 0, pk(0,0,0,0,0,0,0)});
    tbl.push_back('{"tick_idle",        0,1,0,0,0,0, 0, 0,0, 0, pk(0,0,0,0,0,0,0)});
    tbl.push_back('{"load_0001",        0,0,1,0,0,0, 0, 0,0, 1, pk(0,0,0,1,0,0,0)});
    tbl.push_back('{"start_0001",       0,0,0,1,0,0, 0, 0,0, 0, pk(0,0,0,1,1,0,0)});
    tbl.push_back('{"expire",           0,1,0,0,0,0, 0, 0,0, 0, pk(0,0,0,0,0,1,1)});
    tbl.push_back('{"start_expired",    0,0,0,1,0,0, 0, 0,0, 0, pk(0,0,0,0,0,1,1)});
    tbl.push_back('{"load_leaves_exp",  0,1,1,0,1,0, 0, 1,0, 5, pk(0,1,0,5,0,0,0)});
    tbl.push_back('{"idle_tick",        0,1,0,0,0,0, 0, 0,0, 0, pk(0,1,0,5,0,0,0)});

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].t, tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].c,
            tbl[i].mt, tbl[i].mu, tbl[i].st, tbl[i].su);
      check(tbl[i].name, tbl[i].want);
    end

    // Reset in the middle of a run.
    load1(0, 3, 2, 7); start1();
    check("run_0327", pk(0,3,2,7,1,0,0));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_run", pk(0,0,0,0,0,0,0));
    tick1();
    check("tick_after_rst", pk(0,0,0,0,0,0,0));

    // Minutes borrow through 01:00.
    load1(0, 1, 0, 5); start1();
    for (int i = 0; i < 6; i++) tick1();
    check("borrow_0059", pk(0,0,5,9,1,0,0));

    // Expiry and alarm length.
    load1(0, 0, 0, 2); start1(); tick1();
    check("exp_0001", pk(0,0,0,1,1,0,0));
    tick1();
    check("exp_edge", pk(0,0,0,0,0,1,1));
    for (int i = 1; i < ALARM_N; i++) tick1();
    check("alarm_before_last", pk(0,0,0,0,0,1,1));
    tick1();
    check("alarm_drop", pk(0,0,0,0,0,1,0));
    for (int i = 0; i < 3; i++) tick1();
    check("alarm_stays_low", pk(0,0,0,0,0,1,0));
    start1();
    check("start_in_expired", pk(0,0,0,0,0,1,0));
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("pause_in_expired", pk(0,0,0,0,0,1,0));

    // Pause colliding with tick at 00:30.
    load1(0, 0, 3, 1); start1(); tick1();
    check("at_0030", pk(0,0,3,0,1,0,0));
    drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    check("pause_tick_collide", pk(0,0,3,0,0,0,0));
    for (int i = 0; i < 5; i++) tick1();
    check("paused_5_ticks", pk(0,0,3,0,0,0,0));
    start1(); tick1();
    check("resume_0029", pk(0,0,2,9,1,0,0));

    // Load beats tick and pause while running.
    load1(0, 0, 0, 5); start1();
    drive(0, 1, 1, 0, 1, 0, 0, 2, 0, 0);
    check("load_priority", pk(0,2,0,0,0,0,0));

    // Random control traffic against the seconds model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rand_reset", model_vec());
    for (int n = 0; n < 3000; n++) begin
      bit r, t, l, s, p, c;
      int mt, mu, st, su;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 79) == 0);
      l = ($urandom_range(0, 29) == 0);
      p = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 2) == 0);
      if (s || p) t = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        mt = 0; mu = $urandom_range(0, 1); st = $urandom_range(0, 2); su = $urandom_range(0, 15);
      end else begin
        mt = $urandom_range(0, 7); mu = $urandom_range(0, 15);
        st = $urandom_range(0, 7); su = $urandom_range(0, 15);
      end
      drive(r, t, l, s, p, c, mt, mu, st, su);
      check("rand_cycle", model_vec());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_mmss.md
Name: countdown_mmss

Overview:
- Cascaded BCD down-counter timer, MM:SS, 00:00 to 59:59. Mirrors the existing up-counting cascade.
- The user loads a preset, starts it, and it counts down one second per tick. It stops at 00:00, holds an expired flag and raises a finite alarm.
- Digit outputs use the same 4/3/4/3-bit split as the existing counters, so they drive display_hexa directly.
- Sits between the debounced control FSM and the display decoders. Single clock domain: the 1 Hz rate arrives as an enable, not as a derived clock.

Parameters:
- ALARM_TICKS, default 10: number of tick pulses for which alarm stays high after expiry (legal range 1 to 255).
- SEC_TENS_MAX, default 5: maximum tens-of-seconds digit.
- MIN_TENS_MAX, default 5: maximum tens-of-minutes digit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle enable, nominally 1 Hz
- load  in  1  one-cycle pulse: capture preset digits
- start  in  1  one-cycle pulse: begin or resume counting
- pause  in  1  one-cycle pulse: freeze counting
- clear  in  1  one-cycle pulse: zero the timer, go idle
- preset_su  in  4  preset seconds units
- preset_st  in  3  preset seconds tens
- preset_mu  in  4  preset minutes units
- preset_mt  in  3  preset minutes tens
- out1  out  4  seconds units
- out2  out  3  seconds tens
- out3  out  4  minutes units
- out4  out  3  minutes tens
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED
- alarm  out  1  high for ALARM_TICKS ticks after expiry

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - All state updates on the rising edge of clk.
  - On rst: out1..out4 = 0, state IDLE, running = 0, expired = 0, alarm = 0, alarm counter = 0.
- Control priority in any cycle: rst > clear > load > pause > start > tick.
- States: IDLE, RUN, PAUSE, EXPIRED (encoding in the package).
- clear, in any state: digits go to 0, state goes to IDLE, alarm drops next cycle.
- load, in any state:
  - Digits take the clamped preset; state goes to IDLE; expired and alarm clear next cycle.
  - Clamp rule: units digits above 9 become 9; tens digits above their *_TENS_MAX become *_TENS_MAX.
  - Example: preset_st = 7 loads as 5.
- IDLE:
  - start with digits nonzero: go to RUN.
  - start at 00:00: ignored, stay IDLE, no expiry.
  - tick: ignored.
- RUN:
  - tick: decrement by one second. Outputs update on the edge after the tick cycle (1-cycle latency).
  - pause: go to PAUSE. A tick in the same cycle is discarded.
  - start: no effect.
- PAUSE:
  - start: go to RUN. A tick in the same cycle is discarded; counting resumes on the next tick.
  - tick: ignored.
- Decrement rule, as a borrow chain:
  - Seconds units: 0 becomes 9 and borrows.
  - Seconds tens: 0 becomes SEC_TENS_MAX and borrows.
  - Minutes units: 0 becomes 9 and borrows.
  - Minutes tens: decrements only on borrow.
  - Example: 10:00 -> 09:59. 01:00 -> 00:59.
- Expiry:
  - A tick in RUN with value 00:01 produces 00:00 and enters EXPIRED on the same edge.
  - In EXPIRED, expired = 1 and alarm = 1 from that edge.
  - Each subsequent tick increments the alarm counter. alarm drops on the edge of the ALARM_TICKS-th tick after expiry.
  - The counter never wraps. The value never goes below 00:00.
- EXPIRED exits only by load, clear or rst; start, pause and tick have no other effect.
- Output flags:
  - running is high exactly in RUN; expired is high exactly in EXPIRED.
  - All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (timer_pkg):
  - Digit widths: units 4, tens 3.
  - Constants: UNITS_MAX = 9, default tens max = 5.
  - State encoding localparams: IDLE, RUN, PAUSE, EXPIRED.
- One sub-module, bcd_down_digit:
  - Parameters: width, MAX.
  - Inputs: clk, rst, load, load_val, dec_en, clear.
  - Outputs: q, borrow_out. borrow_out is asserted combinationally when q == 0 and dec_en is set.
  - Instantiated four times.
- The top of countdown_mmss holds the FSM, the clamp logic and the alarm counter.

Test Plan:
- Reset: assert rst mid-RUN at 03:27 -> next edge all digits 0, IDLE, running = 0, expired = 0, alarm = 0. A following tick leaves 00:00.
- Borrow chain: load 10:00, start, 1 tick -> 09:59. Load 01:05, start, 6 ticks -> 00:59.
- Expiry: load 00:02, start, 2 ticks -> 00:00 with expired = 1 and alarm = 1 on the 2nd tick's edge. With ALARM_TICKS = 10, alarm drops on the 10th subsequent tick. A further start leaves the state EXPIRED.
- Pause/tick collision: in RUN at 00:30, pause and tick in the same cycle -> stays 00:30 in PAUSE. 5 ticks -> still 00:30. start, then 1 tick -> 00:29.
- Clamp and zero-start:
  - Load preset su = 12, st = 7, mu = 15, mt = 6 -> 59:59.
  - clear, then start -> stays IDLE at 00:00, expired = 0.
- Load priority: in RUN at 00:05, load (preset 02:00) together with tick and pause -> 02:00, IDLE, running = 0.
